// File: rtl/k6502_pkg.sv
// Shared types and constants for the k6502 system bus and sprite DMA.
package k6502_pkg;

    localparam int A_W = 16;
    localparam int D_W = 8;

    localparam logic [A_W-1:0] DMA_REG_ADDR_DEFAULT = 16'h4014;
    localparam logic [A_W-1:0] OAM_DATA_ADDR        = 16'h2004;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

endpackage

// File: rtl/bus_mux.sv
// Combinational CPU/DMA select onto the shared system bus.
module bus_mux
    import k6502_pkg::*;
(
    input  logic           owner,
    input  logic [A_W-1:0] cpu_a,
    input  logic [D_W-1:0] cpu_dout,
    input  logic           cpu_we,
    input  logic [A_W-1:0] dma_a,
    input  logic [D_W-1:0] dma_dout,
    input  logic           dma_we,
    output logic [A_W-1:0] bus_a,
    output logic [D_W-1:0] bus_dout,
    output logic           bus_we
);

    always_comb begin
        bus_a    = owner ? dma_a    : cpu_a;
        bus_dout = owner ? dma_dout : cpu_dout;
        bus_we   = owner ? dma_we   : cpu_we;
    end

endmodule

// File: rtl/oam_dma.sv
// Sprite DMA: on a write to DMA_REG_ADDR, stall the CPU and copy one 256-byte
// page to DEST_ADDR as alternating read/write cycles.
//
// state | meaning
// IDLE  | CPU owns the bus, watching for a trigger write
// HALT  | dummy cycle while the CPU stalls; parity picks ALIGN or READ
// ALIGN | extra dummy cycle so reads start on a fixed parity
// READ  | fetch {page,idx}, latch into data
// WRITE | store data to DEST_ADDR, advance idx or finish
module oam_dma
    import k6502_pkg::*;
#(
    parameter logic [A_W-1:0] DMA_REG_ADDR = DMA_REG_ADDR_DEFAULT,
    parameter logic [A_W-1:0] DEST_ADDR    = OAM_DATA_ADDR
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [A_W-1:0] cpu_a,
    input  logic [D_W-1:0] cpu_dout,
    input  logic           cpu_we,
    output logic           cpu_rdy,
    output logic [A_W-1:0] bus_a,
    output logic [D_W-1:0] bus_dout,
    output logic           bus_we,
    input  logic [D_W-1:0] bus_din,
    output logic           dma_busy
);

    dma_state_t     state;
    dma_state_t     state_next;
    logic [7:0]     page;
    logic [7:0]     idx;
    logic [D_W-1:0] data;
    logic           parity;
    logic           trigger;
    logic           owner;
    logic [A_W-1:0] dma_a;
    logic           dma_we;

    always_comb begin
        state_next = state;
        dma_a      = cpu_a;
        dma_we     = 1'b0;
        trigger    = cpu_we && (cpu_a == DMA_REG_ADDR);
        case (state)
            IDLE:  if (trigger) state_next = HALT;
            HALT:  state_next = parity ? ALIGN : READ;
            ALIGN: state_next = READ;
            READ: begin
                dma_a      = {page, idx};
                state_next = WRITE;
            end
            WRITE: begin
                dma_a      = DEST_ADDR;
                dma_we     = 1'b1;
                state_next = (idx == 8'hFF) ? IDLE : READ;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            page     <= 8'h00;
            idx      <= 8'h00;
            data     <= '0;
            parity   <= 1'b0;
            cpu_rdy  <= 1'b1;
            dma_busy <= 1'b0;
        end else begin
            parity   <= ~parity;
            state    <= state_next;
            cpu_rdy  <= (state_next == IDLE);
            dma_busy <= (state_next != IDLE);
            if (state == IDLE && trigger) begin
                page <= cpu_dout;
                idx  <= 8'h00;
            end
            if (state == READ)
                data <= bus_din;
            // idx holds at FF on the last write; the next trigger reloads it
            if (state == WRITE && idx != 8'hFF)
                idx <= idx + 8'd1;
        end
    end

    assign owner = (state != IDLE);

    bus_mux u_bus_mux (
        .owner    (owner),
        .cpu_a    (cpu_a),
        .cpu_dout (cpu_dout),
        .cpu_we   (cpu_we),
        .dma_a    (dma_a),
        .dma_dout (data),
        .dma_we   (dma_we),
        .bus_a    (bus_a),
        .bus_dout (bus_dout),
        .bus_we   (bus_we)
    );

endmodule
